// File: rtl/nios_system_pio_in_edge.sv
// -----------------------------------------------------------------------------
// nios_system_pio_in_edge
//
// Avalon-MM input PIO slave with per-bit edge capture and interrupt masking.
// External lines pass through a SYNC_STAGES-deep synchroniser.
// The synchronised level is readable live.
// Edges of the kind selected by EDGE_TYPE are latched into an edge-capture
// register.
// irq is the OR of the captured bits that are enabled in irqmask.
//
// Register map (word addresses):
//   0 : data        RO, synchronised input level
//   1 : reserved    reads 0, writes ignored
//   2 : irqmask     RW
//   3 : edgecapture read / clear
//
// Optional feature (macro PIO_IN_BIT_CLEARING_EN):
//   defined   - a write to address 3 clears only the bits written as 1.
//   undefined - any write to address 3 clears every edgecapture bit.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   address    register word address
//   chipselect slave select for writes
//   write_n    active-low write strobe
//   writedata  write data, bits [DATA_WIDTH-1:0] used
//   in_port    asynchronous external inputs
//   readdata   registered read data, zero-extended to 32 bits
//   irq        level interrupt request, active-high
//
// Parameters:
//   DATA_WIDTH  number of input lines (1..32)
//   EDGE_TYPE   0 = rising, 1 = falling, 2 = any
//   SYNC_STAGES synchroniser depth (>= 2)
// -----------------------------------------------------------------------------
module nios_system_pio_in_edge #(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    // Synchroniser chain: stage 0 samples in_port, the last stage is the
    // stable level used by everything downstream.
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0]                  r_prev;
    logic [DATA_WIDTH-1:0]                  r_irqmask;
    logic [DATA_WIDTH-1:0]                  r_edgecap;

    logic [DATA_WIDTH-1:0] w_s;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [31:0]           w_rd_next;
    logic                  w_wr;
    logic                  w_unused;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign w_wr = chipselect & ~write_n;

    // Upper writedata bits are legitimately ignored when DATA_WIDTH < 32.
    assign w_unused = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_s;
        end
    end

    // Per-bit edge detector, selected at elaboration time.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == 0) begin : g_rise
                assign w_edge[gi] = w_s[gi] & ~r_prev[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign w_edge[gi] = ~w_s[gi] & r_prev[gi];
            end else begin : g_any
                assign w_edge[gi] = w_s[gi] ^ r_prev[gi];
            end
        end
    endgenerate

    // Clear vector for the edge-capture register.
`ifdef PIO_IN_BIT_CLEARING_EN
    assign w_clr = (w_wr && address == 2'd3) ? writedata[DATA_WIDTH-1:0]
                                             : {DATA_WIDTH{1'b0}};
`else
    assign w_clr = (w_wr && address == 2'd3) ? {DATA_WIDTH{1'b1}}
                                             : {DATA_WIDTH{1'b0}};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && address == 2'd2) begin
            r_irqmask <= writedata[DATA_WIDTH-1:0];
        end
    end

    // A new edge in the same cycle as a clear keeps its bit set, so an event
    // arriving while software acknowledges older ones is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // Read mux is sampled every cycle regardless of chipselect.
    // Reading address 3 therefore returns the value held before any
    // clear in that same cycle.
    always_comb begin
        w_rd_next = '0;
        case (address)
            2'd0:    w_rd_next[DATA_WIDTH-1:0] = w_s;
            2'd2:    w_rd_next[DATA_WIDTH-1:0] = r_irqmask;
            2'd3:    w_rd_next[DATA_WIDTH-1:0] = r_edgecap;
            default: w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_next;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// -----------------------------------------------------------------------------
// Directed testbench for nios_system_pio_in_edge.
// Three instances share the bus and inputs, one for each EDGE_TYPE:
// dut0 is rising, dut1 is falling and dut2 is any-edge.
// Inputs are driven 1 time unit after a rising clk edge.
// Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_nios_system_pio_in_edge;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;
    logic [31:0] d0, d1, d2;

    int tests = 0;
    int fails = 0;

    nios_system_pio_in_edge #(.DATA_WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    nios_system_pio_in_edge #(.DATA_WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    nios_system_pio_in_edge #(.DATA_WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("[TB] %-26s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick(1);
        d0 = rd0;
        d1 = rd1;
        d2 = rd2;
    endtask

    logic [31:0] exp_ec;
    logic [31:0] exp_irq;

    initial begin
`ifdef PIO_IN_BIT_CLEARING_EN
        exp_ec  = 32'h05;
        exp_irq = 32'h1;
`else
        exp_ec  = 32'h04;
        exp_irq = 32'h0;
`endif
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        tick(2);
        check("reset_readdata", rd0, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);
        reset = 1'b0;
        rd(2'd3);
        check("ec_after_reset", d0, 32'h0);

        // Input transition: readdata at addr 0 updates on the third edge.
        address = 2'd0;
        in_port = 8'hA5;
        tick(2);
        check("data_before_latency", rd0, 32'h0);
        tick(1);
        check("data_at_edge3", rd0, 32'hA5);
        rd(2'd3);
        check("ec_rise_A5", d0, 32'hA5);
        check("ec_fall_A5", d1, 32'h00);
        check("ec_any_A5", d2, 32'hA5);
        wr(2'd3, 32'hFF);
        rd(2'd3);
        check("ec_cleared", d0, 32'h0);

        // irq from a masked capture, then cleared by a write of 1.
        wr(2'd2, 32'h01);
        in_port = 8'hA4;
        tick(4);
        wr(2'd3, 32'hFF);
        in_port = 8'hA5;
        tick(2);
        check("irq_before_capture", {31'b0, irq0}, 32'h0);
        tick(1);
        check("irq_after_capture", {31'b0, irq0}, 32'h1);
        in_port = 8'hA4;
        wr(2'd3, 32'h01);
        check("irq_after_clear", {31'b0, irq0}, 32'h0);

        // A new edge in the same cycle as a clear must win.
        in_port = 8'hA0;
        tick(4);
        wr(2'd3, 32'hFF);
        in_port = 8'hA1;
        tick(4);
        rd(2'd3);
        check("ec_bit0_setup", d0, 32'h01);
        in_port = 8'hA5;
        tick(2);
        wr(2'd3, 32'h02);
        check("rd_preclear", rd0, 32'h01);
        check("irq_after_partial_clr", {31'b0, irq0}, exp_irq);
        rd(2'd3);
        check("ec_set_wins", d0, exp_ec);

        // Mask set/clear drives irq; reserved address reads 0.
        wr(2'd2, 32'h04);
        check("irq_on_mask_set", {31'b0, irq0}, 32'h1);
        rd(2'd2);
        check("irqmask_readback", d0, 32'h04);
        wr(2'd2, 32'h00);
        check("irq_mask_cleared", {31'b0, irq0}, 32'h0);
        wr(2'd1, 32'hFF);
        rd(2'd1);
        check("reserved_reads_0", d0, 32'h0);

        // Falling / any-edge instances.
        in_port = 8'hFF;
        tick(4);
        wr(2'd3, 32'hFF);
        rd(2'd3);
        check("ec_fall_cleared", d1, 32'h0);
        in_port = 8'h0F;
        tick(4);
        rd(2'd3);
        check("rise_FF_to_0F", d0, 32'h00);
        check("fall_FF_to_0F", d1, 32'hF0);
        check("any_FF_to_0F", d2, 32'hF0);
        in_port = 8'hFF;
        tick(4);
        rd(2'd3);
        check("rise_0F_to_FF", d0, 32'hF0);
        check("fall_0F_to_FF", d1, 32'hF0);
        check("any_0F_to_FF", d2, 32'hF0);

        // Asynchronous reset with captures pending and irq high.
        wr(2'd3, 32'hFF);
        in_port = 8'hC3;
        tick(4);
        wr(2'd3, 32'hFF);
        in_port = 8'hFF;
        tick(4);
        wr(2'd2, 32'h3C);
        rd(2'd3);
        check("ec_3C", d0, 32'h3C);
        check("irq_before_reset", {31'b0, irq0}, 32'h1);
        address = 2'd0;
        tick(1);
        check("data_ff", rd0, 32'hFF);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_readdata", rd0, 32'h0);
        check("async_rst_irq", {31'b0, irq0}, 32'h0);
        tick(2);
        reset   = 1'b0;
        address = 2'd3;
        tick(3);
        check("recapture_pending", rd0, 32'h0);
        tick(1);
        check("recapture_rise", rd0, 32'hFF);
        check("recapture_fall", rd1, 32'h00);
        check("recapture_any", rd2, 32'hFF);
        check("irq_mask_reset", {31'b0, irq0}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
